// File: rtl/ahb5_slave_mem.sv
// ahb5_slave_mem
//   AHB5 memory-mapped slave backed by an internal word array. Accepts
//   pipelined address/data-phase transfers, writes with byte-lane enables,
//   inserts WAIT_STATES wait cycles per OKAY transfer and answers illegal
//   accesses with the two-cycle ERROR response.
//
// Ports
//   HCLK       bus clock, rising edge
//   HRESET     synchronous active-high reset
//   HSEL       slave select
//   HADDR      transfer address
//   HTRANS     IDLE/BUSY/NONSEQ/SEQ
//   HWRITE     1 = write, 0 = read
//   HSIZE      byte/half/word (larger sizes are illegal)
//   HBURST     accepted, unused (beats decoded independently)
//   HPROT      accepted, unused
//   HWDATA     write data, valid in the data phase
//   HREADY     bus-level ready
//   HRDATA     read data (registered)
//   HREADYOUT  slave ready (registered)
//   HRESP      0 = OKAY, 1 = ERROR (registered)
module ahb5_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      3'b000:  lane_mask = 4'b0001 << lane;
      3'b001:  lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_word,
                                                        input logic [DATA_WIDTH-1:0] new_word,
                                                        input logic [3:0]            en);
    merge_lanes = old_word;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) merge_lanes[8*i +: 8] = new_word[8*i +: 8];
    end
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  readyout_q;
  logic                  resp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [IDX_W-1:0]      idx_p1;
  logic [1:0]            lane_p1;
  logic [2:0]            size_p1;
  logic                  write_p1;

  logic                  accept_p0;
  logic                  illegal_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic                  commit_p1;
  logic [3:0]            be_p1;
  logic [DATA_WIDTH-1:0] rd_word_p0;
  state_t                launch_state;

  logic                  unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HTRANS[0]};

  // ---- address phase (p0): accept and legality decode ----
  // Accepting only while our own ready is high keeps a misbehaving HREADY
  // from starting a new transfer over one that is still in flight.
  assign accept_p0  = HSEL && HREADY && HTRANS[1] && readyout_q;
  assign illegal_p0 = (HADDR[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_DEPTH))
                   || (HSIZE > 3'b010)
                   || ((HSIZE == 3'b001) && HADDR[0])
                   || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  assign idx_p0     = HADDR[IDX_W+1:2];

  // Write commits at the end of the DATA cycle; reset abandons it.
  assign commit_p1  = (state == ST_DATA) && write_p1 && !HRESET;
  assign be_p1      = lane_mask(size_p1, lane_p1);

  // A read accepted on the same edge a write commits to the same word sees
  // the new bytes.
  assign rd_word_p0 = (commit_p1 && (idx_p1 == idx_p0))
                    ? merge_lanes(mem[idx_p0], HWDATA, be_p1)
                    : mem[idx_p0];

  always_comb begin
    launch_state = ST_IDLE;
    if (accept_p0) begin
      if (illegal_p0)           launch_state = ST_ERR1;
      else if (WAIT_STATES > 0) launch_state = ST_WAIT;
      else                      launch_state = ST_DATA;
    end
  end

  // ---- data phase (p1): FSM with registered bus outputs ----
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      wait_cnt   <= 4'd0;
      readyout_q <= 1'b1;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
      write_p1   <= 1'b0;
    end else begin
      if (accept_p0) write_p1 <= HWRITE;
      if (accept_p0 && !illegal_p0 && !HWRITE) rdata_q <= rd_word_p0;
      case (state)
        ST_IDLE, ST_DATA, ST_ERR2: begin
          state      <= launch_state;
          wait_cnt   <= (launch_state == ST_WAIT) ? 4'(WAIT_STATES) : 4'd0;
          readyout_q <= !((launch_state == ST_WAIT) || (launch_state == ST_ERR1));
          resp_q     <= (launch_state == ST_ERR1);
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            state      <= ST_DATA;
            readyout_q <= 1'b1;
          end
        end
        ST_ERR1: begin
          // ERR2 follows regardless of what the master does meanwhile.
          state      <= ST_ERR2;
          readyout_q <= 1'b1;
          resp_q     <= 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          readyout_q <= 1'b1;
          resp_q     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept_p0) begin
      idx_p1  <= idx_p0;
      lane_p1 <= HADDR[1:0];
      size_p1 <= HSIZE;
    end
  end

  // ---- memory commit ----
  always_ff @(posedge HCLK) begin
    if (commit_p1) mem[idx_p1] <= merge_lanes(mem[idx_p1], HWDATA, be_p1);
  end

  assign HRDATA    = rdata_q;
  assign HREADYOUT = readyout_q;
  assign HRESP     = resp_q;

endmodule

// File: tb/tb_ahb5_slave_mem.sv
module tb_ahb5_slave_mem;

  localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;

  logic [31:0] rdata0, rdata2;
  logic        ready0, ready2, resp0, resp2;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb5_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(ready0), .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
  );

  ahb5_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(ready2), .HRDATA(rdata2), .HREADYOUT(ready2), .HRESP(resp2)
  );

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                            input logic [1:0] tr);
    HSEL   = 1'b1;
    HADDR  = a;
    HWRITE = wr;
    HSIZE  = sz;
    HTRANS = tr;
  endtask

  task automatic drive_idle();
    HSEL   = 1'b0;
    HTRANS = T_IDLE;
    HWRITE = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    drive_idle();
    cyc();
    cyc();
    HRESET = 1'b0;
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ready0); end
    checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL rst_resp: got %b want 0", resp0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata0); end
    // known contents, then a read so HRDATA is non-zero
    drive_addr(32'h50, 1'b1, SZ_W, T_NONSEQ);
    cyc();
    HWDATA = 32'h12345678;
    drive_addr(32'h50, 1'b0, SZ_W, T_NONSEQ);
    cyc();
    drive_idle();
    checks++; if (rdata0 !== 32'h12345678) begin errors++; $display("FAIL rst_pre_read: got %h want 12345678", rdata0); end
    // write abandoned by reset during its data phase
    drive_addr(32'h50, 1'b1, SZ_W, T_NONSEQ);
    cyc();
    HWDATA = 32'hFFFFFFFF;
    drive_idle();
    HRESET = 1'b1;
    cyc();
    cyc();
    HRESET = 1'b0;
    checks++; if (ready0 !== 1'b1 || resp0 !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: ready=%b resp=%b want 1/0", ready0, resp0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h want 0", rdata0); end
    drive_addr(32'h50, 1'b0, SZ_W, T_NONSEQ);
    cyc();
    drive_idle();
    checks++; if (rdata0 !== 32'h12345678) begin errors++; $display("FAIL rst_no_commit: got %h want 12345678", rdata0); end
    cyc();
  endtask

  task automatic test_wr_rd();
    int low = 0;
    drive_addr(32'h10, 1'b1, SZ_W, T_NONSEQ);
    cyc();
    HWDATA = 32'hDEADBEEF;
    drive_idle();
    if (ready0 !== 1'b1) low++;
    cyc();
    drive_addr(32'h10, 1'b0, SZ_W, T_NONSEQ);
    if (ready0 !== 1'b1) low++;
    cyc();
    drive_idle();
    if (ready0 !== 1'b1) low++;
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_word: got %h want deadbeef", rdata0); end
    checks++; if (low !== 0) begin errors++; $display("FAIL wr_rd_ready: low cycles %0d want 0", low); end
    cyc();
  endtask

  task automatic test_byte_merge();
    drive_addr(32'h20, 1'b1, SZ_W, T_NONSEQ);
    cyc();
    HWDATA = 32'h11223344;
    drive_addr(32'h23, 1'b1, SZ_B, T_NONSEQ);
    cyc();
    HWDATA = 32'hAA000000;
    drive_addr(32'h20, 1'b0, SZ_W, T_NONSEQ);
    cyc();
    drive_idle();
    checks++; if (rdata0 !== 32'hAA223344) begin errors++; $display("FAIL byte_merge: got %h want aa223344", rdata0); end
    cyc();
    drive_addr(32'h20, 1'b1, SZ_H, T_NONSEQ);
    cyc();
    HWDATA = 32'h0000BEEF;
    drive_idle();
    cyc();
    drive_addr(32'h20, 1'b0, SZ_W, T_NONSEQ);
    cyc();
    drive_idle();
    checks++; if (rdata0 !== 32'hAA22BEEF) begin errors++; $display("FAIL half_lo_merge: got %h want aa22beef", rdata0); end
    drive_addr(32'h22, 1'b1, SZ_H, T_NONSEQ);
    cyc();
    HWDATA = 32'h55660000;
    drive_addr(32'h20, 1'b0, SZ_W, T_NONSEQ);
    cyc();
    drive_idle();
    checks++; if (rdata0 !== 32'h5566BEEF) begin errors++; $display("FAIL half_hi_merge: got %h want 5566beef", rdata0); end
    cyc();
  endtask

  task automatic test_raw_bypass();
    drive_addr(32'h30, 1'b1, SZ_W, T_NONSEQ);
    cyc();
    HWDATA = 32'hCAFEF00D;
    drive_addr(32'h30, 1'b0, SZ_W, T_NONSEQ);
    cyc();
    drive_idle();
    checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL raw_bypass: got %h want cafef00d", rdata0); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL raw_ready: got %b want 1", ready0); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    int low = 0;
    d[0] = 32'h0BAD_F00D; d[1] = 32'h1357_9BDF; d[2] = 32'h2468_ACE0; d[3] = 32'hFEDC_BA98;
    for (int i = 0; i < 9; i++) begin
      if (i < 4)      drive_addr(32'h60 + 32'(4*i), 1'b1, SZ_W, (i == 0) ? T_NONSEQ : T_SEQ);
      else if (i < 8) drive_addr(32'h60 + 32'(4*(i-4)), 1'b0, SZ_W, (i == 4) ? T_NONSEQ : T_SEQ);
      else            drive_idle();
      if (i >= 1 && i <= 4) HWDATA = d[i-1];
      if (i >= 5) begin
        checks++;
        if (rdata0 !== d[i-5]) begin errors++; $display("FAIL b2b_read%0d: got %h want %h", i-5, rdata0, d[i-5]); end
      end
      if (ready0 !== 1'b1) low++;
      cyc();
    end
    checks++; if (low !== 0) begin errors++; $display("FAIL b2b_ready: low cycles %0d want 0", low); end
  endtask

  task automatic test_error();
    drive_addr(32'h0, 1'b1, SZ_W, T_NONSEQ);
    cyc();
    HWDATA = 32'h01020304;
    drive_idle();
    cyc();
    // out of range write aliases word 0 in the low bits; must not land there
    drive_addr(32'h400, 1'b1, SZ_W, T_NONSEQ);
    cyc();
    HWDATA = 32'hFFFFFFFF;
    drive_idle();
    checks++; if (resp0 !== 1'b1 || ready0 !== 1'b0) begin errors++; $display("FAIL oob_err1: resp=%b ready=%b want 1/0", resp0, ready0); end
    cyc();
    checks++; if (resp0 !== 1'b1 || ready0 !== 1'b1) begin errors++; $display("FAIL oob_err2: resp=%b ready=%b want 1/1", resp0, ready0); end
    cyc();
    checks++; if (resp0 !== 1'b0 || ready0 !== 1'b1) begin errors++; $display("FAIL oob_after: resp=%b ready=%b want 0/1", resp0, ready0); end
    // unselected write is ignored
    HSEL = 1'b0; HTRANS = T_NONSEQ; HADDR = 32'h0; HWRITE = 1'b1; HSIZE = SZ_W;
    cyc();
    HWDATA = 32'hFFFFFFFF;
    drive_addr(32'h0, 1'b0, SZ_W, T_NONSEQ);
    checks++; if (ready0 !== 1'b1 || resp0 !== 1'b0) begin errors++; $display("FAIL hsel0_okay: ready=%b resp=%b want 1/0", ready0, resp0); end
    cyc();
    drive_idle();
    checks++; if (rdata0 !== 32'h01020304) begin errors++; $display("FAIL err_mem_kept: got %h want 01020304", rdata0); end
    // misaligned word read
    drive_addr(32'h2, 1'b0, SZ_W, T_NONSEQ);
    cyc();
    drive_idle();
    checks++; if (resp0 !== 1'b1 || ready0 !== 1'b0) begin errors++; $display("FAIL misal_err1: resp=%b ready=%b want 1/0", resp0, ready0); end
    checks++; if (rdata0 !== 32'h01020304) begin errors++; $display("FAIL misal_rdata: got %h want 01020304", rdata0); end
    cyc();
    drive_addr(32'h10, 1'b0, SZ_W, T_NONSEQ);
    checks++; if (resp0 !== 1'b1 || ready0 !== 1'b1) begin errors++; $display("FAIL misal_err2: resp=%b ready=%b want 1/1", resp0, ready0); end
    cyc();
    drive_idle();
    checks++; if (resp0 !== 1'b0 || ready0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL after_err_read: resp=%b ready=%b data=%h want 0/1/deadbeef", resp0, ready0, rdata0);
    end
    cyc();
    // oversized transfer
    drive_addr(32'h0, 1'b0, 3'b011, T_NONSEQ);
    cyc();
    drive_idle();
    checks++; if (resp0 !== 1'b1 || ready0 !== 1'b0) begin errors++; $display("FAIL size_err1: resp=%b ready=%b want 1/0", resp0, ready0); end
    cyc();
    cyc();
    checks++; if (resp0 !== 1'b0 || ready0 !== 1'b1) begin errors++; $display("FAIL size_after: resp=%b ready=%b want 0/1", resp0, ready0); end
  endtask

  task automatic test_wait_states();
    logic [31:0] exp [4];
    int n;
    int low;
    int total;
    int unstable;
    exp[0] = 32'h1111_0040; exp[1] = 32'h2222_0044; exp[2] = 32'h3333_0048; exp[3] = 32'h4444_004C;
    HRESET = 1'b1;
    drive_idle();
    cyc();
    HRESET = 1'b0;
    for (int b = 0; b < 4; b++) begin
      drive_addr(32'h40 + 32'(4*b), 1'b1, SZ_W, T_NONSEQ);
      cyc();
      HWDATA = exp[b];
      drive_idle();
      n = 0;
      while (ready2 !== 1'b1 && n < 10) begin n++; cyc(); end
      cyc();
    end
    HBURST = 3'b011;
    drive_addr(32'h40, 1'b0, SZ_W, T_NONSEQ);
    cyc();
    total = 0;
    unstable = 0;
    for (int b = 0; b < 4; b++) begin
      if (b < 3) drive_addr(32'h40 + 32'(4*(b+1)), 1'b0, SZ_W, T_SEQ);
      else       drive_idle();
      low = 0;
      while (ready2 !== 1'b1 && low < 10) begin
        if (rdata2 !== exp[b]) unstable++;
        low++; total++;
        cyc();
      end
      total++;
      checks++; if (low !== 2) begin errors++; $display("FAIL ws_low_beat%0d: got %0d want 2", b, low); end
      checks++; if (rdata2 !== exp[b] || resp2 !== 1'b0) begin
        errors++; $display("FAIL ws_data_beat%0d: data=%h resp=%b want %h/0", b, rdata2, resp2, exp[b]);
      end
      cyc();
    end
    HBURST = 3'b000;
    checks++; if (total !== 12) begin errors++; $display("FAIL ws_total: got %0d want 12", total); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL ws_hold: unstable cycles %0d want 0", unstable); end
    checks++; if (ready2 !== 1'b1 || resp2 !== 1'b0) begin errors++; $display("FAIL ws_idle: ready=%b resp=%b want 1/0", ready2, resp2); end
  endtask

  initial begin
    HRESET = 1'b1;
    HSEL   = 1'b0;
    HADDR  = 32'h0;
    HTRANS = T_IDLE;
    HWRITE = 1'b0;
    HSIZE  = SZ_W;
    HBURST = 3'b000;
    HPROT  = 4'b0011;
    HWDATA = 32'h0;
    test_reset();
    test_wr_rd();
    test_byte_merge();
    test_raw_bypass();
    test_back_to_back();
    test_error();
    test_wait_states();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ahb5_slave_mem.md
# ahb5_slave_mem

Synthesizable AHB5 memory-mapped slave: the responder that the AHB5 master VIP drives in closed-loop benches, in place of the behavioural dummy slave driver. It accepts pipelined address/data-phase transfers and stores data in an internal word array with byte-lane writes. It inserts a configurable number of wait states and returns the two-cycle AHB ERROR response for illegal accesses. It sits on the bus between the interface and the monitor/scoreboard path, so the scoreboard can compare against a real pipelined responder.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; 32 only (4 byte lanes)
- MEM_DEPTH, 256, number of DATA_WIDTH words; legal byte addresses 0 .. 4*MEM_DEPTH-1
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY NONSEQ/SEQ data phase (0..15)
- HCLK  input  1  bus clock, all state updates on rising edge
- HRESET  input  1  synchronous, active-high reset
- HSEL  input  1  slave select
- HADDR  input  ADDR_WIDTH  transfer address
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  input  1  1=write, 0=read
- HSIZE  input  3  000 byte, 001 half, 010 word; larger sizes are illegal
- HBURST  input  3  accepted, not used (each beat decoded independently)
- HPROT  input  4  accepted, not used
- HWDATA  input  DATA_WIDTH  write data, valid in the data phase
- HREADY  input  1  bus-level ready (previous transfer complete)
- HRDATA  output  DATA_WIDTH  read data
- HREADYOUT  output  1  slave ready
- HRESP  output  1  0=OKAY, 1=ERROR

## Operation
- Address phase is accepted on a rising edge with HSEL=1, HREADY=1 and HTRANS[1]=1. HADDR, HWRITE and HSIZE are registered. Otherwise no data phase starts.
- IDLE/BUSY, or a transfer with HSEL=0, gets a zero-wait OKAY: HREADYOUT=1, HRESP=0.
- Illegal access is decoded at acceptance. An access is illegal if:
  - the word index HADDR[ADDR_WIDTH-1:2] is >= MEM_DEPTH, or
  - HSIZE > 010, or
  - the address is misaligned (half with HADDR[0]=1; word with HADDR[1:0]!=00).
- States:
  - IDLE: no data phase pending.
  - WAIT: a wait counter loads WAIT_STATES and decrements to 0.
  - DATA: final data-phase cycle, HREADYOUT=1.
  - ERR1: HRESP=1, HREADYOUT=0.
  - ERR2: HRESP=1, HREADYOUT=1.
- Transitions:
  - A legal accept goes to WAIT if WAIT_STATES>0, else to DATA.
  - An illegal accept goes to ERR1 -> ERR2 (always 2 cycles, regardless of WAIT_STATES).
  - From DATA or ERR2, the next state is chosen by a new accept in that same cycle, otherwise IDLE.
- Write: the memory is updated at the end of the DATA cycle with HWDATA.
  - Byte lanes are little-endian: byte lane = HADDR[1:0]; a half uses lanes {HADDR[1],0}+0/1.
  - Unselected lanes are unchanged.
- Read: the memory word is read at address acceptance into the HRDATA register. All 4 lanes are returned.
  - If the read address matches a write committing on the same edge, the written bytes are merged into HRDATA (read-after-write bypass).
- An ERROR transfer never modifies memory and leaves HRDATA unchanged.
- If the master drops HTRANS to IDLE during ERR1, the slave still completes ERR2.
- Memory contents are not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0.
- Reset while a transfer is in flight abandons it: the pending write is not committed, and HRDATA is cleared on the reset edge.
- Read latency is 1+WAIT_STATES cycles after the address-phase edge. HRDATA is valid when HREADYOUT=1 and is held stable through the wait cycles.
- Back-to-back transfers are fully pipelined when WAIT_STATES=0: one transfer per cycle with no bubbles.
- During WAIT/ERR1, HREADY=0 on the bus, so no new address is accepted. The master holds its next address phase until HREADYOUT=1.
- HRESP=1 is asserted exactly 2 cycles per error; HRESP=0 in all other states.

## Test plan
- Reset: hold HRESET=1 for 2 cycles mid-write -> HREADYOUT=1, HRESP=0, HRDATA=0, and the target word is unchanged on a subsequent read.
- Word write then read: NONSEQ write 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF one cycle after the read address phase, HREADYOUT never low.
- Byte write merge: write word 0x11223344 to 0x20, byte write 0xAA to 0x23, read 0x20 -> 0xAA223344. Halfword 0xBEEF to 0x20 -> read 0xAA22BEEF.
- Pipelined RAW bypass: write 0xCAFEF00D to 0x30 immediately followed by read 0x30 (consecutive cycles) -> HRDATA=0xCAFEF00D with no wait.
- Errors (MEM_DEPTH=256):
  - Write to 0x400 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1, memory unchanged.
  - Word read at 0x02 -> same 2-cycle error.
  - A following NONSEQ to 0x10 -> OKAY.
- Wait states (WAIT_STATES=2): 4-beat INCR read from 0x40 -> each beat has HREADYOUT low 2 cycles then high with correct data; total 12 data-phase cycles.
